// File: rtl/cal_requant_acc_int4_pkg.sv
// Shared widths and helpers for the int4 requantizing accumulator slice.
package cal_requant_acc_int4_pkg;

    localparam int INT4_W    = 4;
    localparam int INT12_W   = 12;
    localparam int INT15_W   = 15;
    localparam int DEF_ACC_W = 18;
    localparam int DEF_SHIFT = 4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_round_sat_int4.sv
// Combinational requantizer: round-half-up arithmetic shift, optional ReLU,
// saturation to a signed OUT_W result with a clamp flag.
module requant_round_sat_int4
    import cal_requant_acc_int4_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = INT4_W,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int RELU_EN = 1
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = -MAX_V - (ACC_W+1)'(1);

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shr;
    logic signed [ACC_W:0] clip;

    assign ext = (ACC_W+1)'(sum);
    assign rnd = ext + HALF;
    assign shr = rnd >>> SHIFT;

    // ReLU clamping is intentional and does not count as saturation.
    always_comb begin
        sat  = 1'b0;
        clip = shr;
        if ((RELU_EN != 0) && (shr < 0)) begin
            clip = '0;
        end else if (shr > MAX_V) begin
            clip = MAX_V;
            sat  = 1'b1;
        end else if (shr < MIN_V) begin
            clip = MIN_V;
            sat  = 1'b1;
        end
        res = OUT_W'(clip);
    end

endmodule

// File: rtl/cal_requant_acc_int4.sv
// Accumulates NUM_CH int15 partial sums per output pixel and requantizes the
// group sum to int4 two cycles after the group's last input.
module cal_requant_acc_int4
    import cal_requant_acc_int4_pkg::*;
#(
    parameter int IN_W    = INT15_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = INT4_W,
    parameter int NUM_CH  = 4,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int RELU_EN = 1,
    localparam int CNT_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    din_valid,
    input  logic signed [IN_W-1:0]  din,
    output logic                    dout_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_sat,
    output logic [CNT_W-1:0]        ch_cnt
);

    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

    logic signed [ACC_W-1:0] sx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] sum_r;
    logic                    s2_valid;
    logic signed [OUT_W-1:0] q_res;
    logic                    q_sat;

    // The first channel of a group restarts the sum, so no clear cycle is needed.
    assign sx       = ACC_W'(din);
    assign acc_next = (ch_cnt == '0) ? sx : acc + sx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            ch_cnt   <= '0;
            sum_r    <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= 1'b0;
            if (din_valid) begin
                acc <= acc_next;
                if (ch_cnt == LAST_CH) begin
                    sum_r    <= acc_next;
                    s2_valid <= 1'b1;
                    ch_cnt   <= '0;
                end else begin
                    ch_cnt <= ch_cnt + CNT_W'(1);
                end
            end
        end
    end

    requant_round_sat_int4 #(
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .RELU_EN(RELU_EN)
    ) u_requant (
        .sum(sum_r),
        .res(q_res),
        .sat(q_sat)
    );

    // dout keeps the last result between pulses; the strobes are single-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sat   <= 1'b0;
        end else begin
            dout_valid <= s2_valid;
            dout_sat   <= s2_valid & q_sat;
            if (s2_valid) begin
                dout <= q_res;
            end
        end
    end

endmodule
